// File: rtl/cordic_vector_engine.sv
// Vectoring-mode CORDIC engine: pops one I/Q word from the sample FIFO, returns magnitude and phase.
// Define CORDIC_GAIN_COMP_EN to add a GAIN state that scales the magnitude by 1/K (~0.60725).
module cordic_vector_engine #(
  parameter int DW     = 16,
  parameter int ITER   = 16,
  parameter int RD_LAT = 2,
  parameter int MAGW   = 18
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                FIFO_EMPTY,
  output logic                FIFO_RE,
  input  logic [2*DW-1:0]     FIFO_Q,
  output logic [MAGW-1:0]     OUT_MAG,
  output logic signed [15:0]  OUT_PHASE,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic                BUSY
);
  localparam int XW = DW + 2;
  localparam int CW = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RD,
    PRE,
    ROT,
`ifdef CORDIC_GAIN_COMP_EN
    GAIN,
`endif
    DONE
  } state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        lat_cnt;
  logic [3:0]           rot_i;
  logic                 last_rot;
  logic                 zero_in;
  logic signed [XW-1:0] x, y;
  logic signed [15:0]   z;

  logic signed [DW-1:0] i_in, q_in;
  logic signed [XW-1:0] xe, ye, x_fold, y_fold, x_rot, y_rot, xs, ys;
  logic signed [15:0]   z_fold, z_rot;

  function automatic logic signed [15:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    return 16'sd8192;
      4'd1:    return 16'sd4836;
      4'd2:    return 16'sd2555;
      4'd3:    return 16'sd1297;
      4'd4:    return 16'sd651;
      4'd5:    return 16'sd326;
      4'd6:    return 16'sd163;
      4'd7:    return 16'sd81;
      4'd8:    return 16'sd41;
      4'd9:    return 16'sd20;
      4'd10:   return 16'sd10;
      4'd11:   return 16'sd5;
      4'd12:   return 16'sd3;
      4'd13:   return 16'sd1;
      4'd14:   return 16'sd1;
      default: return 16'sd0;
    endcase
  endfunction

`ifdef CORDIC_GAIN_COMP_EN
  // x is non-negative after vectoring, so truncating the shifted product is a plain floor.
  function automatic logic [MAGW-1:0] gain_comp(input logic signed [XW-1:0] xv);
    logic signed [XW+16:0] prod;
    prod = xv * $signed(17'd39797);
    return MAGW'(prod >>> 16);
  endfunction
`endif

  assign i_in     = FIFO_Q[2*DW-1:DW];
  assign q_in     = FIFO_Q[DW-1:0];
  assign xe       = XW'(i_in);
  assign ye       = XW'(q_in);
  assign last_rot = (rot_i == 4'(ITER - 1));
  assign BUSY     = (state != IDLE);

  // Fold left-half-plane vectors into the right half so the rotations converge.
  always_comb begin
    x_fold = xe;
    y_fold = ye;
    z_fold = 16'sd0;
    if (xe[XW-1]) begin
      if (!ye[XW-1]) begin
        x_fold = ye;
        y_fold = -xe;
        z_fold = 16'sd16384;
      end else begin
        x_fold = -ye;
        y_fold = xe;
        z_fold = -16'sd16384;
      end
    end
  end

  always_comb begin
    xs = x >>> rot_i;
    ys = y >>> rot_i;
    if (!y[XW-1]) begin
      x_rot = x + ys;
      y_rot = y - xs;
      z_rot = z + atan_lut(rot_i);
    end else begin
      x_rot = x - ys;
      y_rot = y + xs;
      z_rot = z - atan_lut(rot_i);
    end
  end

  always_comb begin
    state_nxt = state;
    FIFO_RE   = 1'b0;
    case (state)
      IDLE: begin
        if (!FIFO_EMPTY && !RESET) begin
          FIFO_RE   = 1'b1;
          state_nxt = (RD_LAT > 1) ? WAIT_RD : PRE;
        end
      end
      WAIT_RD: if (lat_cnt == CW'(1)) state_nxt = PRE;
      PRE:     state_nxt = ROT;
`ifdef CORDIC_GAIN_COMP_EN
      ROT:     if (last_rot) state_nxt = GAIN;
      GAIN:    state_nxt = DONE;
`else
      ROT:     if (last_rot) state_nxt = DONE;
`endif
      DONE:    if (OUT_READY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      lat_cnt   <= '0;
      rot_i     <= '0;
      OUT_VALID <= 1'b0;
      OUT_MAG   <= '0;
      OUT_PHASE <= '0;
    end else begin
      case (state)
        IDLE:    lat_cnt <= CW'(RD_LAT - 1);
        WAIT_RD: lat_cnt <= lat_cnt - 1'b1;
        PRE:     rot_i   <= '0;
        ROT: begin
          rot_i <= rot_i + 1'b1;
`ifndef CORDIC_GAIN_COMP_EN
          if (last_rot) begin
            OUT_MAG   <= MAGW'(x_rot);
            OUT_PHASE <= zero_in ? 16'sd0 : z_rot;
            OUT_VALID <= 1'b1;
          end
`endif
        end
`ifdef CORDIC_GAIN_COMP_EN
        GAIN: begin
          OUT_MAG   <= gain_comp(x);
          OUT_PHASE <= zero_in ? 16'sd0 : z;
          OUT_VALID <= 1'b1;
        end
`endif
        DONE:    if (OUT_READY) OUT_VALID <= 1'b0;
        default: ;
      endcase
    end
  end

  // ---- datapath: load folded vector in PRE, one micro-rotation per ROT cycle ----
  always_ff @(posedge CLK) begin
    if (state == PRE) begin
      x       <= x_fold;
      y       <= y_fold;
      z       <= z_fold;
      zero_in <= (i_in == '0) && (q_in == '0);
    end else if (state == ROT) begin
      x <= x_rot;
      y <= y_rot;
      z <= z_rot;
    end
  end

endmodule

// File: tb/tb_cordic_vector_engine.sv
// Directed bench for cordic_vector_engine: FIFO model with read latency, table of vectors, corner sequences.
module tb_cordic_vector_engine;
  localparam int DW     = 16;
  localparam int ITER   = 16;
  localparam int RD_LAT = 2;
  localparam int MAGW   = 18;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int EXP_LAT = 20;
`else
  localparam int EXP_LAT = 19;
`endif

  logic                CLK = 1'b0;
  logic                RESET = 1'b1;
  logic                FIFO_EMPTY = 1'b1;
  logic                FIFO_RE;
  logic [2*DW-1:0]     FIFO_Q = 32'hA5A5_5A5A;
  logic [MAGW-1:0]     OUT_MAG;
  logic signed [15:0]  OUT_PHASE;
  logic                OUT_VALID;
  logic                OUT_READY = 1'b0;
  logic                BUSY;

  cordic_vector_engine #(.DW(DW), .ITER(ITER), .RD_LAT(RD_LAT), .MAGW(MAGW)) dut (
    .CLK(CLK), .RESET(RESET), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_RE(FIFO_RE), .FIFO_Q(FIFO_Q),
    .OUT_MAG(OUT_MAG), .OUT_PHASE(OUT_PHASE), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // FIFO model: data of a pop is presented only in the cycle RD_LAT after the RE cycle.
  logic [31:0] fifo[$];
  int          re_count = 0;
  int          re_cyc = 0;
  int          underflow = 0;
  logic [31:0] pd[RD_LAT];
  bit          pv[RD_LAT];

  initial begin
    bit re_now;
    int c_now;
    for (int k = 0; k < RD_LAT; k++) begin
      pv[k] = 1'b0;
      pd[k] = '0;
    end
    forever begin
      @(negedge CLK);
      re_now = FIFO_RE;
      c_now  = cyc;
      @(posedge CLK);
      #1;
      for (int k = RD_LAT - 1; k > 0; k--) begin
        pv[k] = pv[k-1];
        pd[k] = pd[k-1];
      end
      pv[0] = 1'b0;
      if (re_now) begin
        re_count++;
        re_cyc = c_now;
        if (fifo.size() > 0) begin
          pd[0] = fifo.pop_front();
          pv[0] = 1'b1;
        end else begin
          underflow++;
        end
      end
      FIFO_Q     = pv[RD_LAT-1] ? pd[RD_LAT-1] : 32'hA5A5_5A5A;
      FIFO_EMPTY = (fifo.size() == 0);
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp, input int tol);
    int d;
    d = act - exp;
    if (d < 0) d = -d;
    n_chk++;
    if (d > tol) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  task automatic chk_ph(input string name, input logic signed [15:0] act, input int exp,
                        input int tol);
    logic signed [15:0] d;
    int ad;
    d  = act - 16'(exp);
    ad = (d < 0) ? -int'(d) : int'(d);
    n_chk++;
    if (ad > tol) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (tol %0d, modulo 2^16)", name, act, exp, tol);
    end
  endtask

  task automatic wait_valid(input string name, output int vc, output int mag,
                            output logic signed [15:0] ph);
    int k;
    k   = 0;
    vc  = -1;
    mag = 0;
    ph  = '0;
    while (k < 200) begin
      @(negedge CLK);
      if (OUT_VALID) begin
        vc  = cyc;
        mag = int'(OUT_MAG);
        ph  = OUT_PHASE;
        break;
      end
      k++;
    end
    if (vc < 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s_timeout: got no OUT_VALID expected one within 200 cycles", name);
    end
  endtask

  typedef struct {
    logic signed [15:0] i;
    logic signed [15:0] q;
    int mag_raw;
    int mag_cmp;
    int mag_tol;
    int ph;
    int ph_tol;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int vc, mag, base, bad, k, exp_mag;
    logic signed [15:0] ph;

    vecs[0] = '{16'sd16384,  16'sd0,      26981, 16384, 4, 0,      2};
    vecs[1] = '{16'sd0,      16'sd16384,  26981, 16384, 4, 16384,  2};
    vecs[2] = '{16'sd10000,  16'sd10000,  23289, 14142, 4, 8192,   3};
    vecs[3] = '{-16'sd16384, 16'sd0,      26981, 16384, 4, 32768,  4};
    vecs[4] = '{-16'sd32768, -16'sd32768, 76310, 46341, 6, -24576, 3};
    vecs[5] = '{16'sd0,      16'sd0,      0,     0,     0, 0,      0};

    // Reset state
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("rst_valid", int'(OUT_VALID), 0, 0);
    chk("rst_busy", int'(BUSY), 0, 0);
    chk("rst_re", int'(FIFO_RE), 0, 0);
    chk("rst_mag", int'(OUT_MAG), 0, 0);
    chk_ph("rst_phase", OUT_PHASE, 0, 0);

    // Empty FIFO for 50 cycles: nothing may happen
    bad = 0;
    base = re_count;
    repeat (50) begin
      @(negedge CLK);
      if (FIFO_RE || BUSY || OUT_VALID) bad++;
    end
    chk("empty_quiet_cycles", bad, 0, 0);
    chk("empty_no_pop", re_count - base, 0, 0);

    // Table-driven single words with OUT_READY high
    OUT_READY = 1'b1;
    for (int v = 0; v < 6; v++) begin
`ifdef CORDIC_GAIN_COMP_EN
      exp_mag = vecs[v].mag_cmp;
`else
      exp_mag = vecs[v].mag_raw;
`endif
      fifo.push_back({vecs[v].i, vecs[v].q});
      wait_valid($sformatf("v%0d", v), vc, mag, ph);
      if (vc >= 0) begin
        chk($sformatf("v%0d_latency", v), vc - re_cyc, EXP_LAT, 0);
        chk($sformatf("v%0d_mag", v), mag, exp_mag, vecs[v].mag_tol);
        chk_ph($sformatf("v%0d_phase", v), ph, vecs[v].ph, vecs[v].ph_tol);
        @(negedge CLK);
        chk($sformatf("v%0d_valid_drop", v), int'(OUT_VALID), 0, 0);
        chk($sformatf("v%0d_mag_retained", v), int'(OUT_MAG), exp_mag, vecs[v].mag_tol);
        chk($sformatf("v%0d_idle", v), int'(BUSY), 0, 0);
      end
    end

    // Back-pressure: three words queued, result held 40 cycles, one read outstanding
    OUT_READY = 1'b0;
    base = re_count;
    fifo.push_back({16'sd16384, 16'sd0});
    fifo.push_back({16'sd0, 16'sd16384});
    fifo.push_back({16'sd10000, 16'sd10000});
`ifdef CORDIC_GAIN_COMP_EN
    exp_mag = 16384;
`else
    exp_mag = 26981;
`endif
    wait_valid("bp_a", vc, mag, ph);
    chk_ph("bp_a_phase", ph, 0, 2);
    chk("bp_a_reads", re_count - base, 1, 0);
    bad = 0;
    repeat (40) begin
      @(negedge CLK);
      k = int'(OUT_MAG) - exp_mag;
      if (k < 0) k = -k;
      if (!OUT_VALID || k > 4 || OUT_PHASE > 16'sd2 || OUT_PHASE < -16'sd2 || FIFO_RE) bad++;
    end
    chk("bp_hold_cycles", bad, 0, 0);
    chk("bp_still_one_read", re_count - base, 1, 0);
    OUT_READY = 1'b1;
    wait_valid("bp_b", vc, mag, ph);
    chk_ph("bp_b_phase", ph, 16384, 2);
    wait_valid("bp_c", vc, mag, ph);
    chk_ph("bp_c_phase", ph, 8192, 3);
    chk("bp_total_reads", re_count - base, 3, 0);

    // Reset pulse while rotating: first word dropped, second word processed
    base = re_count;
    fifo.push_back({16'sd10000, 16'sd10000});
    fifo.push_back({16'sd0, 16'sd16384});
    k = 0;
    while (re_count == base && k < 50) begin
      @(negedge CLK);
      k++;
    end
    chk("mid_rst_first_read", re_count - base, 1, 0);
    repeat (8) @(negedge CLK);
    chk("mid_rst_busy_before", int'(BUSY), 1, 0);
    @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("mid_rst_busy", int'(BUSY), 0, 0);
    chk("mid_rst_valid", int'(OUT_VALID), 0, 0);
    chk("mid_rst_mag", int'(OUT_MAG), 0, 0);
    chk_ph("mid_rst_phase", OUT_PHASE, 0, 0);
    wait_valid("mid_rst_next", vc, mag, ph);
    chk_ph("mid_rst_next_phase", ph, 16384, 2);
`ifdef CORDIC_GAIN_COMP_EN
    chk("mid_rst_next_mag", mag, 16384, 4);
`else
    chk("mid_rst_next_mag", mag, 26981, 4);
`endif
    chk("mid_rst_total_reads", re_count - base, 2, 0);

    repeat (5) @(negedge CLK);
    chk("no_pop_when_empty", underflow, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
